// File: rtl/hex_digit_counter_if.sv
// Control/status bundle between the display logic and hex_digit_counter.
// master drives controls and preset value; slave (the counter) returns count and status pulses.
interface hex_digit_counter_if #(
  parameter int DIGITS = 4
);
  logic                enable;
  logic                up;
  logic                clear;
  logic                load;
  logic [4*DIGITS-1:0] load_value;
  logic [4*DIGITS-1:0] count;
  logic                step;
  logic                wrap;

  modport master (
    output enable, up, clear, load, load_value,
    input  count, step, wrap
  );

  modport slave (
    input  enable, up, clear, load, load_value,
    output count, step, wrap
  );
endinterface

// File: rtl/hex_digit_counter.sv
// Prescaled multi-digit up/down counter feeding seven-segment decoders.
// Define BCD_MODE_EN to make each digit count 0..9 instead of 0..F.
module hex_digit_counter #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50000000
) (
  input logic           clk,
  input logic           rst_n,
  hex_digit_counter_if.slave bus
);

  localparam int W  = 4 * DIGITS;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

`ifdef BCD_MODE_EN
  localparam logic [3:0] DIGIT_MAX = 4'h9;
`else
  localparam logic [3:0] DIGIT_MAX = 4'hF;
`endif

  localparam logic [W-1:0] COUNT_MAX = {DIGITS{DIGIT_MAX}};

  logic [PW-1:0] presc_q, presc_d;
  logic [W-1:0]  count_q, count_d;
  logic          step_q,  step_d;
  logic          wrap_q,  wrap_d;

  // Ripple one step through the digits; a digit at or above DIGIT_MAX rolls
  // to 0 on an up step so loaded out-of-range BCD digits recover cleanly.
  function automatic logic [W-1:0] next_count(input logic [W-1:0] cur,
                                              input logic         dir_up);
    logic [W-1:0] res;
    logic         ripple;
    logic [3:0]   d;
    res    = cur;
    ripple = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      d = cur[4*i +: 4];
      if (ripple) begin
        if (dir_up) begin
          ripple         = (d >= DIGIT_MAX);
          res[4*i +: 4]  = ripple ? 4'h0 : d + 4'h1;
        end else begin
          ripple         = (d == 4'h0);
          res[4*i +: 4]  = ripple ? DIGIT_MAX : d - 4'h1;
        end
      end
    end
    return res;
  endfunction

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    presc_d = presc_q;
    count_d = count_q;
    step_d  = 1'b0;
    wrap_d  = 1'b0;
    if (bus.clear) begin
      presc_d = '0;
      count_d = '0;
    end else if (bus.load) begin
      presc_d = '0;
      count_d = bus.load_value;
    end else if (bus.enable) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        count_d = next_count(count_q, bus.up);
        step_d  = 1'b1;
        wrap_d  = bus.up ? (count_q == COUNT_MAX) : (count_q == '0);
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q <= '0;
      count_q <= '0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      count_q <= count_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.count = count_q;
  assign bus.step  = step_q;
  assign bus.wrap  = wrap_q;

endmodule

// File: tb/tb_hex_digit_counter.sv
// Directed bench for hex_digit_counter (hex mode, DIGITS=4, PRESCALE=4).
// Each scenario task checks {count, step, wrap} against hand-computed values.
module tb_hex_digit_counter;

  localparam int DIGITS   = 4;
  localparam int PRESCALE = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  hex_digit_counter_if #(.DIGITS(DIGITS)) bus_if ();

  hex_digit_counter #(.DIGITS(DIGITS), .PRESCALE(PRESCALE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, landing 1 ns after the last edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus_if.enable = 1'b1;
    bus_if.up = 1'b1;
    bus_if.clear = 1'b0;
    bus_if.load = 1'b1;
    bus_if.load_value = 16'h1234;
    tick(2);
    checks++;
    if ({bus_if.count, bus_if.step, bus_if.wrap} !== {16'h0000, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state: got count=%h step=%b wrap=%b want 0000/0/0",
               bus_if.count, bus_if.step, bus_if.wrap);
    end
    bus_if.load = 1'b0;
    rst_n = 1'b1;
    tick(3);
    checks++;
    if ({bus_if.count, bus_if.step} !== {16'h0000, 1'b0}) begin
      failures++;
      $display("FAIL early_step: got count=%h step=%b want 0000/0", bus_if.count, bus_if.step);
    end
    tick(1);
    checks++;
    if ({bus_if.count, bus_if.step, bus_if.wrap} !== {16'h0001, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL first_step: got count=%h step=%b wrap=%b want 0001/1/0",
               bus_if.count, bus_if.step, bus_if.wrap);
    end
    tick(1);
    checks++;
    if (bus_if.step !== 1'b0) begin
      failures++;
      $display("FAIL step_pulse_width: got step=%b want 0", bus_if.step);
    end
    tick(3);
    checks++;
    if ({bus_if.count, bus_if.step} !== {16'h0002, 1'b1}) begin
      failures++;
      $display("FAIL second_step: got count=%h step=%b want 0002/1", bus_if.count, bus_if.step);
    end
    tick(4);
    checks++;
    if ({bus_if.count, bus_if.step} !== {16'h0003, 1'b1}) begin
      failures++;
      $display("FAIL third_step: got count=%h step=%b want 0003/1", bus_if.count, bus_if.step);
    end
  endtask

  task automatic test_wrap_up();
    bus_if.load = 1'b1;
    bus_if.load_value = 16'hFFFE;
    bus_if.up = 1'b1;
    tick(1);
    bus_if.load = 1'b0;
    checks++;
    if ({bus_if.count, bus_if.step} !== {16'hFFFE, 1'b0}) begin
      failures++;
      $display("FAIL load_value: got count=%h step=%b want fffe/0", bus_if.count, bus_if.step);
    end
    tick(4);
    checks++;
    if ({bus_if.count, bus_if.step, bus_if.wrap} !== {16'hFFFF, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL up_to_max: got count=%h step=%b wrap=%b want ffff/1/0",
               bus_if.count, bus_if.step, bus_if.wrap);
    end
    tick(4);
    checks++;
    if ({bus_if.count, bus_if.step, bus_if.wrap} !== {16'h0000, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL up_wrap: got count=%h step=%b wrap=%b want 0000/1/1",
               bus_if.count, bus_if.step, bus_if.wrap);
    end
    tick(1);
    checks++;
    if ({bus_if.step, bus_if.wrap} !== 2'b00) begin
      failures++;
      $display("FAIL wrap_pulse_width: got step=%b wrap=%b want 0/0", bus_if.step, bus_if.wrap);
    end
  endtask

  task automatic test_wrap_down();
    // Phase is 1 here; direction changes mid-phase and is sampled at the step edge.
    bus_if.up = 1'b0;
    tick(3);
    checks++;
    if ({bus_if.count, bus_if.step, bus_if.wrap} !== {16'hFFFF, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL down_wrap: got count=%h step=%b wrap=%b want ffff/1/1",
               bus_if.count, bus_if.step, bus_if.wrap);
    end
  endtask

  task automatic test_carry();
    bus_if.load = 1'b1;
    bus_if.load_value = 16'h00FF;
    bus_if.up = 1'b1;
    tick(1);
    bus_if.load = 1'b0;
    tick(4);
    checks++;
    if ({bus_if.count, bus_if.step, bus_if.wrap} !== {16'h0100, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL up_carry: got count=%h step=%b wrap=%b want 0100/1/0",
               bus_if.count, bus_if.step, bus_if.wrap);
    end
    bus_if.up = 1'b0;
    tick(4);
    checks++;
    if ({bus_if.count, bus_if.step, bus_if.wrap} !== {16'h00FF, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL down_borrow: got count=%h step=%b wrap=%b want 00ff/1/0",
               bus_if.count, bus_if.step, bus_if.wrap);
    end
  endtask

  task automatic test_enable_hold();
    int step_seen;
    bus_if.enable = 1'b0;
    bus_if.load = 1'b1;
    bus_if.load_value = 16'h0000;
    bus_if.up = 1'b1;
    tick(1);
    bus_if.load = 1'b0;
    bus_if.enable = 1'b1;
    tick(2);
    bus_if.enable = 1'b0;
    step_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (bus_if.step !== 1'b0 || bus_if.count !== 16'h0000) step_seen++;
    end
    checks++;
    if (step_seen != 0) begin
      failures++;
      $display("FAIL hold_while_disabled: got %0d cycles with step or count change want 0", step_seen);
    end
    bus_if.enable = 1'b1;
    tick(1);
    checks++;
    if ({bus_if.count, bus_if.step} !== {16'h0000, 1'b0}) begin
      failures++;
      $display("FAIL resume_early: got count=%h step=%b want 0000/0", bus_if.count, bus_if.step);
    end
    tick(1);
    checks++;
    if ({bus_if.count, bus_if.step} !== {16'h0001, 1'b1}) begin
      failures++;
      $display("FAIL resume_phase: got count=%h step=%b want 0001/1", bus_if.count, bus_if.step);
    end
  endtask

  task automatic test_clear_load();
    // Phase is 0 after the previous step; three edges bring it to the step edge.
    tick(3);
    bus_if.clear = 1'b1;
    bus_if.load = 1'b1;
    bus_if.load_value = 16'h1234;
    tick(1);
    bus_if.clear = 1'b0;
    bus_if.load = 1'b0;
    checks++;
    if ({bus_if.count, bus_if.step, bus_if.wrap} !== {16'h0000, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL clear_over_load: got count=%h step=%b wrap=%b want 0000/0/0",
               bus_if.count, bus_if.step, bus_if.wrap);
    end
    tick(3);
    checks++;
    if (bus_if.step !== 1'b0) begin
      failures++;
      $display("FAIL clear_restart_early: got step=%b want 0", bus_if.step);
    end
    tick(1);
    checks++;
    if ({bus_if.count, bus_if.step} !== {16'h0001, 1'b1}) begin
      failures++;
      $display("FAIL clear_restart: got count=%h step=%b want 0001/1", bus_if.count, bus_if.step);
    end
    tick(3);
    rst_n = 1'b0;
    bus_if.clear = 1'b1;
    bus_if.load = 1'b1;
    tick(1);
    rst_n = 1'b1;
    bus_if.clear = 1'b0;
    bus_if.load = 1'b0;
    checks++;
    if ({bus_if.count, bus_if.step, bus_if.wrap} !== {16'h0000, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_priority: got count=%h step=%b wrap=%b want 0000/0/0",
               bus_if.count, bus_if.step, bus_if.wrap);
    end
    tick(4);
    checks++;
    if ({bus_if.count, bus_if.step} !== {16'h0001, 1'b1}) begin
      failures++;
      $display("FAIL reset_restart: got count=%h step=%b want 0001/1", bus_if.count, bus_if.step);
    end
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_carry();
    test_enable_hold();
    test_clear_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
